// File: rtl/dmem_if.sv
// Shared data-memory bus: memory-stage data port, fetch port and the
// single-port SRAM side, bundled for the arbiter and its environment.
interface dmem_if #(
  parameter int DEPTH = 2048
);
  localparam int AW = $clog2(DEPTH);

  logic          d_req;
  logic          d_we;
  logic [63:0]   d_addr;
  logic [63:0]   d_wdata;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          d_err;

  logic          f_req;
  logic [63:0]   f_addr;
  logic          f_ack;
  logic [63:0]   f_rdata;
  logic          f_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  // Arbiter side.
  modport slave (
    input  d_req, d_we, d_addr, d_wdata, f_req, f_addr, mem_rdata,
    output d_ack, d_rdata, d_err, f_ack, f_rdata, f_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters + SRAM side.
  modport master (
    output d_req, d_we, d_addr, d_wdata, f_req, f_addr, mem_rdata,
    input  d_ack, d_rdata, d_err, f_ack, f_rdata, f_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (data over fetch, with fetch starvation guard) in front of
// a single-port SRAM with one-cycle read latency; one access per two cycles.
module dmem_arbiter #(
  parameter int DEPTH      = 2048,
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, DRESP, FRESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          d_ack_q, f_ack_q;
  logic          err_q;
  logic          rd_q;     // response carries SRAM read data

  logic d_in, f_in, starve_hit, d_win, f_win;

  assign d_in       = bus.d_addr < 64'(DEPTH);
  assign f_in       = bus.f_addr < 64'(DEPTH);
  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
  assign f_win      = (state == IDLE) && bus.f_req && (!bus.d_req || starve_hit);
  assign d_win      = (state == IDLE) && bus.d_req && !f_win;

  // SRAM is driven in the grant cycle itself; out-of-range grants never touch it.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      if (d_win && d_in) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr[AW-1:0];
        bus.mem_wdata = bus.d_wdata;
      end else if (f_win && f_in) begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = bus.f_addr[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      d_ack_q    <= 1'b0;
      f_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d_ack_q <= 1'b0;
          f_ack_q <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= 1'b0;
          if (d_win) begin
            state   <= DRESP;
            d_ack_q <= 1'b1;
            err_q   <= !d_in;
            rd_q    <= d_in && !bus.d_we;
            if (!bus.f_req)
              starve_cnt <= '0;
            else if (!starve_hit)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (f_win) begin
            state      <= FRESP;
            f_ack_q    <= 1'b1;
            err_q      <= !f_in;
            rd_q       <= f_in;
            starve_cnt <= '0;
          end else if (!bus.f_req) begin
            starve_cnt <= '0;
          end
        end
        DRESP, FRESP: begin
          state   <= IDLE;
          d_ack_q <= 1'b0;
          f_ack_q <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          d_ack_q <= 1'b0;
          f_ack_q <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  // SRAM data lands in the response cycle, so it is steered straight through.
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_ack_q && err_q;
  assign bus.d_rdata = (d_ack_q && rd_q) ? bus.mem_rdata : 64'd0;
  assign bus.f_ack   = f_ack_q;
  assign bus.f_err   = f_ack_q && err_q;
  assign bus.f_rdata = (f_ack_q && rd_q) ? bus.mem_rdata : 64'd0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port SRAM.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dmem_if #(.DEPTH(2048)) bus ();

  dmem_arbiter #(.DEPTH(2048), .STARVE_MAX(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] sram [2048] = '{default: '0};
  logic [63:0] rd_q = '0;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= sram[bus.mem_addr];
    end
  assign bus.mem_rdata = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data access from an IDLE negedge; returns at the IDLE negedge after the response.
  task automatic dacc(input string tag, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic exp_en,
                      input logic exp_err, input logic [63:0] exp_rdata);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    #1;
    chk({tag, " grant mem_en"}, 64'(bus.mem_en), 64'(exp_en));
    if (exp_en) begin
      chk({tag, " grant mem_we"}, 64'(bus.mem_we), 64'(we));
      chk({tag, " grant mem_addr"}, 64'(bus.mem_addr), addr);
      if (we) chk({tag, " grant mem_wdata"}, bus.mem_wdata, wdata);
    end
    @(negedge clk);
    chk({tag, " d_ack"}, 64'(bus.d_ack), 64'd1);
    chk({tag, " f_ack"}, 64'(bus.f_ack), 64'd0);
    chk({tag, " d_err"}, 64'(bus.d_err), 64'(exp_err));
    chk({tag, " d_rdata"}, bus.d_rdata, exp_rdata);
    chk({tag, " resp mem_en"}, 64'(bus.mem_en), 64'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk({tag, " d_ack drop"}, 64'(bus.d_ack), 64'd0);
  endtask

  task automatic facc(input string tag, input logic [63:0] addr, input logic exp_en,
                      input logic exp_err, input logic [63:0] exp_rdata);
    bus.f_req = 1'b1; bus.f_addr = addr;
    #1;
    chk({tag, " grant mem_en"}, 64'(bus.mem_en), 64'(exp_en));
    chk({tag, " grant mem_we"}, 64'(bus.mem_we), 64'd0);
    if (exp_en) chk({tag, " grant mem_addr"}, 64'(bus.mem_addr), addr);
    @(negedge clk);
    chk({tag, " f_ack"}, 64'(bus.f_ack), 64'd1);
    chk({tag, " d_ack"}, 64'(bus.d_ack), 64'd0);
    chk({tag, " f_err"}, 64'(bus.f_err), 64'(exp_err));
    chk({tag, " f_rdata"}, bus.f_rdata, exp_rdata);
    bus.f_req = 1'b0;
    @(negedge clk);
    chk({tag, " f_ack drop"}, 64'(bus.f_ack), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'd3; bus.d_wdata = 64'h55;
    bus.f_req = 1'b0; bus.f_addr = '0;

    // Reset state, with a request pending that must not reach the SRAM.
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst d_ack", 64'(bus.d_ack), 64'd0);
    chk("rst f_ack", 64'(bus.f_ack), 64'd0);
    chk("rst d_err", 64'(bus.d_err), 64'd0);
    chk("rst f_err", 64'(bus.f_err), 64'd0);
    chk("rst d_rdata", bus.d_rdata, 64'd0);
    chk("rst f_rdata", bus.f_rdata, 64'd0);
    chk("rst sram[3]", sram[3], 64'd0);
    @(negedge clk);
    reset = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);

    dacc("wr0", 1'b1, 64'd0, 64'h1234, 1'b1, 1'b0, 64'd0);
    dacc("wr5", 1'b1, 64'd5, 64'hDEAD, 1'b1, 1'b0, 64'd0);
    chk("sram[5]", sram[5], 64'hDEAD);
    dacc("rd5", 1'b0, 64'd5, 64'd0, 1'b1, 1'b0, 64'hDEAD);
    facc("f0", 64'd0, 1'b1, 1'b0, 64'h1234);

    // Out of range: no SRAM write, error flagged, zero data.
    dacc("wr2048", 1'b1, 64'd2048, 64'hBAD, 1'b0, 1'b1, 64'd0);
    chk("sram[0] intact", sram[0], 64'h1234);
    dacc("rdhuge", 1'b0, 64'hFFFF_0000_0000_0005, 64'd0, 1'b0, 1'b1, 64'd0);
    dacc("rd0", 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h1234);
    facc("f4096", 64'd4096, 1'b0, 1'b1, 64'd0);

    // Both ports held: D,D,D,D,F repeating.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd5;
    bus.f_req = 1'b1; bus.f_addr = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("starve d_ack %0d", i), 64'(bus.d_ack), 64'((i % 5) != 4));
      chk($sformatf("starve f_ack %0d", i), 64'(bus.f_ack), 64'((i % 5) == 4));
      chk($sformatf("starve d_rdata %0d", i), bus.d_rdata, ((i % 5) != 4) ? 64'hDEAD : 64'd0);
      chk($sformatf("starve f_rdata %0d", i), bus.f_rdata, ((i % 5) == 4) ? 64'h1234 : 64'd0);
      @(negedge clk);
      if (i == 9) begin
        bus.d_req = 1'b0; bus.f_req = 1'b0;
      end else begin
        #1;
        chk($sformatf("starve regrant %0d", i), 64'(bus.mem_en), 64'd1);
      end
    end
    @(negedge clk);
    chk("starve idle d_ack", 64'(bus.d_ack), 64'd0);
    chk("starve idle f_ack", 64'(bus.f_ack), 64'd0);

    // Reset in the response cycle drops the ack; the request then completes.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'd7; bus.d_wdata = 64'h77;
    bus.f_req = 1'b1; bus.f_addr = 64'd0;
    @(negedge clk);
    chk("rstmid d_ack before", 64'(bus.d_ack), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid d_ack", 64'(bus.d_ack), 64'd0);
    chk("rstmid state", 64'(u_dut.state), 64'd0);
    chk("rstmid starve_cnt", 64'(u_dut.starve_cnt), 64'd0);
    chk("rstmid mem_en", 64'(bus.mem_en), 64'd0);
    bus.f_req = 1'b0; bus.d_wdata = 64'h78;
    @(negedge clk);
    chk("rstmid held d_ack", 64'(bus.d_ack), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reissue d_ack", 64'(bus.d_ack), 64'd1);
    chk("reissue d_err", 64'(bus.d_err), 64'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    dacc("rd7", 1'b0, 64'd7, 64'd0, 1'b1, 1'b0, 64'h78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
